// File: rtl/scs8hd_anoi_pkg.sv
// -----------------------------------------------------------------------------
// scs8hd_anoi_pkg
// Shared limits and helpers for the pipelined and-or-invert array.
//   MAX_*            legal upper bounds for the top-level parameters
//   lane_slice()     base bit of lane c inside the packed A bus
//   anoi_params_ok() elaboration-time legality check of the parameter set
// -----------------------------------------------------------------------------
package scs8hd_anoi_pkg;

  localparam int MAX_DEPTH    = 4;
  localparam int MAX_N_AND    = 8;
  localparam int MAX_CHANNELS = 32;

  // Lane c owns A[c*n_and +: n_and].
  function automatic int lane_slice(input int c, input int n_and);
    return c * n_and;
  endfunction

  function automatic bit anoi_params_ok(input int n_and, input int channels,
                                        input int depth, input int sticky);
    return (n_and >= 2) && (n_and <= MAX_N_AND) &&
           (channels >= 1) && (channels <= MAX_CHANNELS) &&
           (depth >= 1) && (depth <= MAX_DEPTH) &&
           ((sticky == 0) || (sticky == 1));
  endfunction

endpackage

// File: rtl/scs8hd_anoi_stage.sv
// -----------------------------------------------------------------------------
// scs8hd_anoi_stage
// One valid-qualified register stage of the AOI pipeline.
//   clk, resetb    clock, asynchronous active-low reset (data -> ones, valid -> 0)
//   en             advance enable; 0 freezes both data and valid
//   in_valid/data  upstream beat
//   out_valid/data registered beat; data only loads on a valid beat
// -----------------------------------------------------------------------------
module scs8hd_anoi_stage #(
  parameter int CHANNELS = 1
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                en,
  input  logic                in_valid,
  input  logic [CHANNELS-1:0] in_data,
  output logic                out_valid,
  output logic [CHANNELS-1:0] out_data
);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      out_valid <= 1'b0;
      out_data  <= '1;
    end else if (en) begin
      out_valid <= in_valid;
      // Invalid beats move the valid bit along but leave data untouched,
      // so downstream Y never glitches on a bubble.
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/scs8hd_anoi_pipe.sv
// -----------------------------------------------------------------------------
// scs8hd_anoi_pipe
// Registered array of and-or-invert lanes: Y[c] = ~(&A_lane(c) | B1[c]),
// delayed by DEPTH valid-qualified stages, with optional sticky-low capture.
//   CLK, RESETB        clock, asynchronous active-low reset
//   EN                 pipeline advance enable (freezes stages and sticky state)
//   IN_VALID, A, B1    input beat; lane c uses A[c*N_AND +: N_AND]
//   STICKY_CLR         synchronous clear of the sticky state (STICKY=1 only)
//   Y, OUT_VALID       registered result and its qualifier
//   vpwr/vgnd/vpb/vnb  power pins when SC_USE_PG_PIN is defined
// -----------------------------------------------------------------------------
module scs8hd_anoi_pipe
  import scs8hd_anoi_pkg::*;
#(
  parameter int N_AND    = 3,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 1,
  parameter int STICKY   = 0
) (
  input  logic                      CLK,
  input  logic                      RESETB,
  input  logic                      EN,
  input  logic                      IN_VALID,
  input  logic [CHANNELS*N_AND-1:0] A,
  input  logic [CHANNELS-1:0]       B1,
  input  logic                      STICKY_CLR,
  output logic [CHANNELS-1:0]       Y,
  output logic                      OUT_VALID
`ifdef SC_USE_PG_PIN
  ,
  input  logic                      vpwr,
  input  logic                      vgnd,
  input  logic                      vpb,
  input  logic                      vnb
`endif
);

  if (!anoi_params_ok(N_AND, CHANNELS, DEPTH, STICKY)) begin : g_param_check
    $error("scs8hd_anoi_pipe: illegal N_AND/CHANNELS/DEPTH/STICKY");
  end

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif

  logic [CHANNELS-1:0] core;
  logic [DEPTH:0]      vld;
  logic [CHANNELS-1:0] dat [DEPTH+1];
  logic [CHANNELS-1:0] y_core;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign core[c] = ~((&A[lane_slice(c, N_AND) +: N_AND]) | B1[c]);
  end

  assign vld[0] = IN_VALID;
  assign dat[0] = core;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    scs8hd_anoi_stage #(.CHANNELS(CHANNELS)) u_stage (
      .clk       (CLK),
      .resetb    (RESETB),
      .en        (EN),
      .in_valid  (vld[k]),
      .in_data   (dat[k]),
      .out_valid (vld[k+1]),
      .out_data  (dat[k+1])
    );
  end

  assign OUT_VALID = vld[DEPTH];

  if (STICKY != 0) begin : g_sticky
    // S loads in parallel with the last stage (fed by the same beat), so it
    // adds no latency; the last stage still provides OUT_VALID.
    logic [CHANNELS-1:0] s_q;
    logic [CHANNELS-1:0] s_d;
    logic                unused_tail;

    always_comb begin
      s_d = s_q;
      if (vld[DEPTH-1]) begin
        s_d = STICKY_CLR ? dat[DEPTH-1] : (s_q & dat[DEPTH-1]);
      end else if (STICKY_CLR) begin
        s_d = '1;
      end
    end

    always_ff @(posedge CLK or negedge RESETB) begin
      if (!RESETB) s_q <= '1;
      else if (EN) s_q <= s_d;
    end

    assign y_core      = s_q;
    assign unused_tail = ^dat[DEPTH];
  end else begin : g_plain
    logic unused_clr;
    assign y_core     = dat[DEPTH];
    assign unused_clr = STICKY_CLR;
  end

  // Power-good gate: output is undefined unless the rails are correct.
  logic pwr_good;
  logic unused_bias;
  assign pwr_good    = (vpwr == 1'b1) && (vgnd == 1'b0);
  assign Y           = pwr_good ? y_core : {CHANNELS{1'bx}};
  assign unused_bias = vpb ^ vnb;

endmodule

// File: tb/tb_scs8hd_anoi_pipe.sv
module tb_scs8hd_anoi_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  // small plain instance: N_AND=3, CHANNELS=2, DEPTH=2, STICKY=0
  logic en_a, iv_a, clr_a, ov_a;
  logic [5:0] a_a;
  logic [1:0] b_a, y_a;
  // small sticky instance: N_AND=3, CHANNELS=2, DEPTH=2, STICKY=1
  logic en_s, iv_s, clr_s, ov_s;
  logic [5:0] a_s;
  logic [1:0] b_s, y_s;
  // wide instance: N_AND=8, CHANNELS=32, DEPTH=4, STICKY=0
  logic en_w, iv_w, clr_w, ov_w;
  logic [255:0] a_w;
  logic [31:0]  b_w, y_w;

  scs8hd_anoi_pipe #(.N_AND(3), .CHANNELS(2), .DEPTH(2), .STICKY(0)) dut_a (
    .CLK(clk), .RESETB(rst_b), .EN(en_a), .IN_VALID(iv_a), .A(a_a), .B1(b_a),
    .STICKY_CLR(clr_a), .Y(y_a), .OUT_VALID(ov_a));

  scs8hd_anoi_pipe #(.N_AND(3), .CHANNELS(2), .DEPTH(2), .STICKY(1)) dut_s (
    .CLK(clk), .RESETB(rst_b), .EN(en_s), .IN_VALID(iv_s), .A(a_s), .B1(b_s),
    .STICKY_CLR(clr_s), .Y(y_s), .OUT_VALID(ov_s));

  scs8hd_anoi_pipe #(.N_AND(8), .CHANNELS(32), .DEPTH(4), .STICKY(0)) dut_w (
    .CLK(clk), .RESETB(rst_b), .EN(en_w), .IN_VALID(iv_w), .A(a_w), .B1(b_w),
    .STICKY_CLR(clr_w), .Y(y_w), .OUT_VALID(ov_w));

  // ---------------- reference model ----------------
  function automatic logic [31:0] aoi_ref(input logic [255:0] a, input logic [31:0] b,
                                          input int n, input int ch);
    logic [31:0] r;
    r = '1;
    for (int c = 0; c < ch; c++) begin
      bit all1;
      all1 = 1'b1;
      for (int i = 0; i < n; i++) if (a[c*n+i] !== 1'b1) all1 = 1'b0;
      r[c] = !(all1 || (b[c] === 1'b1));
    end
    return r;
  endfunction

  // History of samples taken on enabled edges; a sample leaves DEPTH-1
  // enabled edges after it was taken, which is when it becomes visible.
  bit          hv[$];
  logic [31:0] hd[$];
  logic [31:0] m_s, m_y;
  bit          m_ov;

  task automatic model_reset();
    hv.delete();
    hd.delete();
    m_s  = '1;
    m_y  = '1;
    m_ov = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit v, input logic [31:0] d,
                            input bit clr, input int depth, input bit sticky);
    bit          xv;
    logic [31:0] xd;
    if (en) begin
      hv.push_back(v);
      hd.push_back(d);
      xv = 1'b0;
      xd = '1;
      if (hv.size() >= depth) begin
        xv = hv.pop_front();
        xd = hd.pop_front();
      end
      m_ov = xv;
      if (sticky) begin
        if (clr) m_s = xv ? xd : '1;
        else if (xv) m_s = m_s & xd;
        m_y = m_s;
      end else if (xv) begin
        m_y = xd;
      end
    end
  endtask

  // ---------------- helpers ----------------
  task automatic idle_all();
    en_a = 0; iv_a = 0; clr_a = 0; a_a = '0; b_a = '0;
    en_s = 0; iv_s = 0; clr_s = 0; a_s = '0; b_s = '0;
    en_w = 0; iv_w = 0; clr_w = 0; a_w = '0; b_w = '0;
  endtask

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic do_reset();
    idle_all();
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    model_reset();
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [5:0] rand_a6();
    logic [5:0] v;
    v = 6'($urandom);
    if ($urandom_range(0, 2) == 0) v[2:0] = 3'b111;
    if ($urandom_range(0, 2) == 0) v[5:3] = 3'b111;
    return v;
  endfunction

  function automatic logic [255:0] rand_a256();
    logic [255:0] v;
    logic [7:0]   lane;
    for (int c = 0; c < 32; c++) begin
      lane = 8'($urandom);
      if ($urandom_range(0, 1) == 0) lane = 8'hFF;
      v[c*8 +: 8] = lane;
    end
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] r;
    do_reset();
    en_a = 1; en_s = 1; en_w = 1;
    iv_a = 1; iv_s = 1; iv_w = 1;
    for (int i = 0; i < 4; i++) begin
      a_a = 6'b000111; b_a = 2'b00;
      a_s = 6'b000111; b_s = 2'b00;
      a_w = rand_a256(); b_w = '0;
      tick();
    end
    // mid-cycle, far from any clock edge
    #3 rst_b = 1'b0;
    #1;
    n_cmp++; if (y_a !== 2'b11 || ov_a !== 1'b0) begin n_bad++;
      $display("FAIL reset_async_a: got y=%b ov=%b want y=11 ov=0", y_a, ov_a); end
    n_cmp++; if (y_s !== 2'b11 || ov_s !== 1'b0) begin n_bad++;
      $display("FAIL reset_async_s: got y=%b ov=%b want y=11 ov=0", y_s, ov_s); end
    n_cmp++; if (y_w !== 32'hFFFF_FFFF || ov_w !== 1'b0) begin n_bad++;
      $display("FAIL reset_async_w: got y=%h ov=%b want y=ffffffff ov=0", y_w, ov_w); end
    @(posedge clk); #1;
    rst_b = 1'b1;
    model_reset();
    iv_a = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ov_a !== 1'b0 || y_a !== 2'b11) begin n_bad++;
        $display("FAIL reset_flush: cycle %0d got y=%b ov=%b want y=11 ov=0", i, y_a, ov_a); end
    end
    a_a = 6'b111000; b_a = 2'b00; iv_a = 1;
    r = aoi_ref(256'(a_a), 32'(b_a), 3, 2);
    tick();
    iv_a = 0;
    n_cmp++; if (ov_a !== 1'b0) begin n_bad++;
      $display("FAIL reset_first_edge1: got ov=%b want 0", ov_a); end
    tick();
    n_cmp++; if (ov_a !== 1'b1 || y_a !== r[1:0]) begin n_bad++;
      $display("FAIL reset_first_edge2: got y=%b ov=%b want y=%b ov=1", y_a, ov_a, r[1:0]); end
  endtask

  task automatic test_latency();
    logic [31:0] r;
    do_reset();
    en_a = 1;
    // lane0 takes A[2:0]=000 -> 1, lane1 takes A[5:3]=111 -> 0
    a_a = 6'b111_000; b_a = 2'b00; iv_a = 1;
    r = aoi_ref(256'(a_a), 32'(b_a), 3, 2);
    tick();
    iv_a = 0; a_a = '0; b_a = 2'b11;
    n_cmp++; if (ov_a !== 1'b0 || y_a !== 2'b11) begin n_bad++;
      $display("FAIL latency_edge1: got y=%b ov=%b want y=11 ov=0", y_a, ov_a); end
    tick();
    n_cmp++; if (ov_a !== 1'b1 || y_a !== r[1:0]) begin n_bad++;
      $display("FAIL latency_edge2: got y=%b ov=%b want y=%b ov=1", y_a, ov_a, r[1:0]); end
    tick();
    n_cmp++; if (ov_a !== 1'b0 || y_a !== r[1:0]) begin n_bad++;
      $display("FAIL latency_hold: got y=%b ov=%b want y=%b ov=0", y_a, ov_a, r[1:0]); end
  endtask

  task automatic test_en_stall();
    logic [31:0] r;
    do_reset();
    en_a = 1;
    a_a = 6'b000_111; b_a = 2'b00; iv_a = 1;
    r = aoi_ref(256'(a_a), 32'(b_a), 3, 2);
    tick();
    iv_a = 0; en_a = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (ov_a !== 1'b0 || y_a !== 2'b11) begin n_bad++;
        $display("FAIL stall_hold: cycle %0d got y=%b ov=%b want y=11 ov=0", i, y_a, ov_a); end
    end
    en_a = 1;
    tick();
    n_cmp++; if (ov_a !== 1'b1 || y_a !== r[1:0]) begin n_bad++;
      $display("FAIL stall_release: got y=%b ov=%b want y=%b ov=1", y_a, ov_a, r[1:0]); end
    en_a = 0;
    tick();
    n_cmp++; if (ov_a !== 1'b1 || y_a !== r[1:0]) begin n_bad++;
      $display("FAIL stall_freeze_valid: got y=%b ov=%b want y=%b ov=1", y_a, ov_a, r[1:0]); end
  endtask

  task automatic test_invalid_hold();
    logic [31:0] r;
    do_reset();
    en_a = 1;
    a_a = 6'b011_101; b_a = 2'b00; iv_a = 1;
    r = aoi_ref(256'(a_a), 32'(b_a), 3, 2);
    tick();
    a_a = 6'b111_111; b_a = 2'b11; iv_a = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (ov_a !== 1'b0 || y_a !== r[1:0]) begin n_bad++;
        $display("FAIL invalid_hold: cycle %0d got y=%b ov=%b want y=%b ov=0", i, y_a, ov_a, r[1:0]); end
    end
  endtask

  task automatic test_sticky();
    bit         t_en  [13];
    bit         t_iv  [13];
    bit         t_clr [13];
    logic [5:0] t_a   [13];
    logic [1:0] t_b   [13];
    bit         t_y0  [13];
    bit         t_ov  [13];
    logic [31:0] r;
    t_en  = '{1,1,1,1,1,1,1,1,1,1,0,1,0};
    t_iv  = '{1,1,1,1,0,1,0,0,0,1,0,0,0};
    t_clr = '{0,0,0,0,1,0,1,0,1,0,1,0,1};
    t_a   = '{6'b010111, 6'b010000, 6'b010110, 6'b010000, 6'b111111, 6'b010000,
              6'b111111, 6'b111111, 6'b111111, 6'b010011, 6'b111111, 6'b111111, 6'b111111};
    t_b   = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01,
              2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};
    t_y0  = '{1,0,0,0,1,1,0,0,1,1,1,0,0};
    t_ov  = '{0,1,1,1,1,0,1,0,0,0,0,1,1};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      en_s = t_en[i]; iv_s = t_iv[i]; clr_s = t_clr[i]; a_s = t_a[i]; b_s = t_b[i];
      r = aoi_ref(256'(a_s), 32'(b_s), 3, 2);
      @(posedge clk);
      model_edge(en_s, iv_s, r, clr_s, 2, 1'b1);
      #1;
      n_cmp++; if (y_s !== {1'b1, t_y0[i]} || ov_s !== t_ov[i]) begin n_bad++;
        $display("FAIL sticky_row%0d: got y=%b ov=%b want y=%b ov=%b",
                 i, y_s, ov_s, {1'b1, t_y0[i]}, t_ov[i]); end
      n_cmp++; if (y_s !== m_y[1:0] || ov_s !== m_ov) begin n_bad++;
        $display("FAIL sticky_model_row%0d: got y=%b ov=%b want y=%b ov=%b",
                 i, y_s, ov_s, m_y[1:0], m_ov); end
    end
  endtask

  task automatic test_random_sticky();
    logic [31:0] r;
    int bad_here;
    bad_here = 0;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      en_s  = ($urandom_range(0, 4) != 0);
      iv_s  = ($urandom_range(0, 9) < 6);
      clr_s = ($urandom_range(0, 9) == 0);
      a_s   = rand_a6();
      b_s   = 2'($urandom_range(0, 3) == 0 ? $urandom : 0);
      r = aoi_ref(256'(a_s), 32'(b_s), 3, 2);
      @(posedge clk);
      model_edge(en_s, iv_s, r, clr_s, 2, 1'b1);
      #1;
      n_cmp++; if (y_s !== m_y[1:0] || ov_s !== m_ov) begin n_bad++; bad_here++;
        if (bad_here <= 10)
          $display("FAIL random_sticky: beat %0d got y=%b ov=%b want y=%b ov=%b",
                   i, y_s, ov_s, m_y[1:0], m_ov); end
    end
  endtask

  task automatic test_sweep_wide();
    logic [31:0] r;
    int bad_here;
    bad_here = 0;
    do_reset();
    en_w = 1;
    a_w = rand_a256(); b_w = 32'($urandom) & 32'($urandom); iv_w = 1;
    r = aoi_ref(a_w, b_w, 8, 32);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      model_edge(en_w, iv_w, aoi_ref(a_w, b_w, 8, 32), clr_w, 4, 1'b0);
      #1;
      iv_w = 0;
      if (e < 4) begin
        n_cmp++; if (ov_w !== 1'b0) begin n_bad++;
          $display("FAIL wide_latency_early: edge %0d got ov=%b want 0", e, ov_w); end
      end else begin
        n_cmp++; if (ov_w !== 1'b1 || y_w !== r) begin n_bad++;
          $display("FAIL wide_latency_edge4: got y=%h ov=%b want y=%h ov=1", y_w, ov_w, r); end
      end
    end
    for (int i = 0; i < 10000; i++) begin
      en_w  = ($urandom_range(0, 4) != 0);
      iv_w  = ($urandom_range(0, 9) < 7);
      clr_w = $urandom_range(0, 1);
      a_w   = rand_a256();
      b_w   = 32'($urandom) & 32'($urandom) & 32'($urandom);
      r = aoi_ref(a_w, b_w, 8, 32);
      @(posedge clk);
      model_edge(en_w, iv_w, r, clr_w, 4, 1'b0);
      #1;
      n_cmp++; if (y_w !== m_y || ov_w !== m_ov) begin n_bad++; bad_here++;
        if (bad_here <= 10)
          $display("FAIL wide_sweep: beat %0d got y=%h ov=%b want y=%h ov=%b",
                   i, y_w, ov_w, m_y, m_ov); end
    end
  endtask

  initial begin
    idle_all();
    rst_b = 1'b0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_latency();
    test_en_stall();
    test_invalid_hold();
    test_sticky();
    test_random_sticky();
    test_sweep_wide();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
